// File: rtl/multdiv_seq_unit_if.sv
// Bus between the processor-side multdiv issue logic and the iterative unit.
// The master drives operands and start strobes; the slave returns result, exception and ready.
interface multdiv_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_seq_unit.sv
// Iterative signed multiply/divide unit. Works on operand magnitudes with a
// 2*WIDTH accumulator (shift-add for MULT, restoring shift-subtract for DIV),
// then applies the sign and flags overflow / divide-by-zero in a FIX cycle.
// Optional feature macro: MULTDIV_ZERO_SKIP_EN (zero operand jumps straight to FIX).
module multdiv_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  multdiv_seq_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;

  // Start decode: MULT has priority when both strobes are high.
  logic             start;
  logic             start_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             zero_op;

  assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign a_mag     = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
  assign b_mag     = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;
  assign zero_op   = (bus.data_operandA == '0) | (bus.data_operandB == '0);

  // One shift-add multiply step: conditionally add the multiplicand into the
  // upper half, then shift the whole accumulator right (carry enters at the top).
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step: shift the dividend bit into the partial remainder,
  // subtract the divisor when it fits and shift the quotient bit in at the bottom.
  logic [WIDTH:0]     div_trial;
  logic               div_fits;
  logic [WIDTH:0]     div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_fits  = div_trial >= {1'b0, mcand_q};
  assign div_rem   = div_fits ? (div_trial - {1'b0, mcand_q}) : div_trial;
  assign div_next  = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_fits};

  // Sign application and exception detection used in the FIX cycle.
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH:0]     prod_top;
  logic               mul_exc;
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   quo_signed;
  logic               div_exc;

  assign prod_signed = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
  // Overflow when the upper half is not a sign-extension of the low half.
  assign mul_exc     = ~((&prod_top) | ~(|prod_top));
  assign quo_mag     = acc_q[WIDTH-1:0];
  // A zero quotient stays zero rather than being negated.
  assign quo_signed  = (neg_q && (quo_mag != '0)) ? (~quo_mag + 1'b1) : quo_mag;
  // A positive quotient with the MSB set only arises from MIN_INT / -1.
  assign div_exc     = divz_q | (~neg_q & quo_mag[WIDTH-1]);

  // Next-state and datapath control; any start, in any state, reloads the unit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    divz_d   = divz_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (start) begin
      cnt_d    = '0;
      is_div_d = start_div;
      neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      divz_d   = start_div & (bus.data_operandB == '0);
      if (start_div) begin
        mcand_d = b_mag;
        acc_d   = {{WIDTH{1'b0}}, a_mag};
      end else begin
        mcand_d = a_mag;
        acc_d   = {{WIDTH{1'b0}}, b_mag};
      end
`ifdef MULTDIV_ZERO_SKIP_EN
      // A zero operand means a zero magnitude result; a cleared accumulator
      // lets FIX produce it directly (divide-by-zero is overridden there).
      if (zero_op) begin
        acc_d   = '0;
        state_d = S_FIX;
      end else begin
        state_d = S_RUN;
      end
`else
      state_d = S_RUN;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_RUN: begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          if (is_div_q) begin
            result_d = divz_q ? '0 : quo_signed;
            exc_d    = div_exc;
          end else begin
            result_d = prod_signed[WIDTH-1:0];
            exc_d    = mul_exc;
          end
          rdy_d   = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

`ifndef MULTDIV_ZERO_SKIP_EN
  // Zero-operand decode is only consumed by the skip path.
  logic unused_zero_op;
  assign unused_zero_op = zero_op;
`endif

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      divz_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      divz_q   <= divz_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_seq_unit.sv
// Self-checking bench for multdiv_seq_unit: directed vector table, random ops
// against an arithmetic reference model, abort, reset and dual-start sequences.
module tb_multdiv_seq_unit;

  localparam int W = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  multdiv_seq_unit_if #(.WIDTH(W)) bus ();

  multdiv_seq_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain signed arithmetic on 64-bit integers.
  task automatic model(input logic m, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc);
    longint sa, sb, p, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      p   = sa * sb;
      res = p[31:0];
      exc = (p != longint'($signed(p[31:0])));
    end else if (sb == 0) begin
      res = 32'd0;
      exc = 1'b1;
    end else begin
      q   = sa / sb;
      res = q[31:0];
      exc = (q > 64'sd2147483647);
    end
  endtask

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return W + 1;
  endfunction

  // Drive a start strobe for one edge (E0) and return after the inputs are released.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  // Start an op, wait (bounded) for RDY and check latency, values and pulse width.
  task automatic run_op(input string name, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee);
    int lat;
    int want_lat;
    logic [31:0] prev;
    lat      = 0;
    want_lat = exp_latency(a, b);
    prev     = bus.data_result;
    start_op(m, d, a, b);
    while (lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      if (lat == 1 && want_lat > 1)
        chk({name, "_hold"}, 64'(bus.data_result), 64'(prev));
      if (bus.data_resultRDY === 1'b1) break;
    end
    chk({name, "_lat"}, 64'(lat), 64'(want_lat));
    chk({name, "_res"}, 64'(bus.data_result), 64'(er));
    chk({name, "_exc"}, 64'(bus.data_exception), 64'(ee));
    @(posedge clock);
    #1;
    chk({name, "_rdy_off"}, 64'(bus.data_resultRDY), 64'(0));
    $display("op %s m=%0b d=%0b a=%h b=%h res=%h exc=%0b lat=%0d",
             name, m, d, a, b, bus.data_result, bus.data_exception, lat);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return MIN_INT;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] er, a, b;
    logic        ee, m;
    int          lat, rdy_seen;

    vecs[0] = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'd0,         1'b1};
    vecs[2] = '{1'b1, 1'b0, MIN_INT,        32'hFFFF_FFFF, MIN_INT,       1'b1};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'd100,        32'd0,         32'd0,         1'b1};
    vecs[5] = '{1'b0, 1'b1, MIN_INT,        32'hFFFF_FFFF, MIN_INT,       1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'd9,          32'd3,         32'd27,        1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'd0,          32'd5,         32'd0,         1'b0};
    vecs[8] = '{1'b0, 1'b1, MIN_INT,        32'd1,         MIN_INT,       1'b0};
    vecs[9] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0};

    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_res", 64'(bus.data_result), 64'(0));
    chk("reset_exc", 64'(bus.data_exception), 64'(0));
    chk("reset_rdy", 64'(bus.data_resultRDY), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].exc);

    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1));
      a = pick_operand();
      b = pick_operand();
      model(m, a, b, er, ee);
      run_op($sformatf("rnd%0d", i), m, ~m, a, b, er, ee);
    end

    // Abort: MULT 3*5, then DIV 20/4 ten edges later; only the DIV completes.
    rdy_seen = 0;
    start_op(1'b1, 1'b0, 32'd3, 32'd5);
    for (int i = 1; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY === 1'b1) rdy_seen++;
    end
    start_op(1'b0, 1'b1, 32'd20, 32'd4);
    lat = 0;
    while (lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      if (bus.data_resultRDY === 1'b1) break;
    end
    chk("abort_early_rdy", 64'(rdy_seen), 64'(0));
    chk("abort_lat", 64'(lat), 64'(W + 1));
    chk("abort_res", 64'(bus.data_result), 64'(5));
    chk("abort_exc", 64'(bus.data_exception), 64'(0));
    $display("op abort res=%h lat=%0d early_rdy=%0d", bus.data_result, lat, rdy_seen);

    // Async reset between edges mid-RUN; outputs clear at once, no stale RDY later.
    run_op("pre_rst", 1'b1, 1'b0, 32'd9, 32'd3, 32'd27, 1'b0);
    start_op(1'b1, 1'b0, 32'd11, 32'd13);
    repeat (5) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_res", 64'(bus.data_result), 64'(0));
    chk("async_rst_exc", 64'(bus.data_exception), 64'(0));
    chk("async_rst_rdy", 64'(bus.data_resultRDY), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY === 1'b1) rdy_seen++;
    end
    chk("post_rst_no_rdy", 64'(rdy_seen), 64'(0));
    $display("op reset_mid_run rdy_after=%0d", rdy_seen);
    run_op("post_rst", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
